// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared 16-bit ALU (IDLE/EXEC/DONE).
// ALU_ARB_RR_EN selects round-robin tie-break; otherwise req0 has fixed priority.
module alu_share_arbiter #(
  parameter int DW  = 16,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic [OPW-1:0] op0,
  input  logic [DW-1:0]  a0,
  input  logic [DW-1:0]  b0,
  input  logic           req1,
  input  logic [OPW-1:0] op1,
  input  logic [DW-1:0]  a1,
  input  logic [DW-1:0]  b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [DW-1:0]  result,
  output logic           zero,
  output logic           busy,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_zero
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state, state_nx;
  logic   last_win;
  logic   winner;
  logic   pick;
  logic   take;

  always_comb begin
    pick = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (req0 && req1) pick = ~last_win;
    else              pick = req1;
`else
    // last_win never decides here: with req0 low, take implies req1
    pick = ~req0 & (req1 | last_win);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          take     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner   <= 1'b0;
      last_win <= 1'b1;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      result   <= '0;
      zero     <= 1'b0;
    end else begin
      if (take) begin
        winner   <= pick;
        last_win <= pick;
        alu_op   <= pick ? op1 : op0;
        alu_a    <= pick ? a1  : a0;
        alu_b    <= pick ? b1  : b0;
      end
      if (state == EXEC) begin
        result <= alu_result;
        zero   <= alu_zero;
      end
    end
  end

  assign gnt0  = (state == EXEC) && !winner;
  assign gnt1  = (state == EXEC) &&  winner;
  assign done0 = (state == DONE) && !winner;
  assign done1 = (state == DONE) &&  winner;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a small behavioural ALU.
// Directed vectors; a negedge monitor pops expected results on every done.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] result;
  logic        zero, busy;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        id;
    logic [15:0] r;
    logic        z;
  } exp_t;
  exp_t q[$];

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (done0 || done1)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none",
                 done0, done1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_both", {31'd0, done0 & done1}, 32'd0);
        chk("done_id", {31'd0, done1}, {31'd0, e.id});
        chk("result", {16'd0, result}, {16'd0, e.r});
        chk("zero", {31'd0, zero}, {31'd0, e.z});
      end
    end
  end

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (done0 || done1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 8 cycles", nm);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {25'd0, gnt0, gnt1, done0, done1, busy, zero, 1'b0},
        32'd0);
    chk({nm, "_op"}, {29'd0, alu_op}, 32'd0);
    chk({nm, "_a"}, {16'd0, alu_a}, 32'd0);
    chk({nm, "_b"}, {16'd0, alu_b}, 32'd0);
    chk({nm, "_res"}, {16'd0, result}, 32'd0);
  endtask

  // Called at a negedge with the DUT idle; one op, no competing request.
  task automatic do_op(input logic id, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic z);
    q.push_back('{id, r, z});
    if (id) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    @(negedge clk);
    chk("gnt_win", {31'd0, id ? gnt1 : gnt0}, 32'd1);
    chk("gnt_lose", {31'd0, id ? gnt0 : gnt1}, 32'd0);
    chk("busy_exec", {31'd0, busy}, 32'd1);
    chk("alu_a_lat", {16'd0, alu_a}, {16'd0, a});
    chk("alu_op_lat", {29'd0, alu_op}, {29'd0, op});
    @(negedge clk);
    chk("done_win", {31'd0, id ? done1 : done0}, 32'd1);
    chk("done_lose", {31'd0, id ? done0 : done1}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd1);
    if (id) req1 = 0;
    else    req0 = 0;
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("done_idle", {30'd0, done0, done1}, 32'd0);
  endtask

  initial begin
    int t1, t2;
    rst_n = 0;
    req0 = 0; req1 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // single add 5+3
    do_op(1'b0, 3'b010, 16'h0005, 16'h0003, 16'h0008, 1'b0);

    // reset in the middle of EXEC aborts the op
    req0 = 1; op0 = 3'b010; a0 = 16'h0011; b0 = 16'h0022;
    @(posedge clk);
    #2;
    chk("pre_abort_gnt", {31'd0, gnt0}, 32'd1);
    rst_n = 0;
    #1;
    chk_all_zero("abort");
    req0 = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", {31'd0, busy}, 32'd0);

    // normal op after the abort
    do_op(1'b0, 3'b001, 16'h00F0, 16'h000F, 16'h00FF, 1'b0);

    // zero flag from requester 1
    do_op(1'b1, 3'b110, 16'h1234, 16'h1234, 16'h0000, 1'b1);

    // operand stability: a0 changes after grant
    q.push_back('{1'b0, 16'h0101, 1'b0});
    req0 = 1; op0 = 3'b010; a0 = 16'h0100; b0 = 16'h0001;
    @(negedge clk);
    a0 = 16'hFFFF;
    chk("stab_alu_a_exec", {16'd0, alu_a}, 32'h0100);
    wait_done("stab");
    req0 = 0;
    repeat (2) @(negedge clk);
    chk("stab_alu_a_hold", {16'd0, alu_a}, 32'h0100);
    chk("stab_result_hold", {16'd0, result}, 32'h0101);

    // back-to-back with req0 held: done spacing of 3 cycles
    q.push_back('{1'b0, 16'h000F, 1'b0});
    q.push_back('{1'b0, 16'h000F, 1'b0});
    req0 = 1; op0 = 3'b010; a0 = 16'h0007; b0 = 16'h0008;
    wait_done("b2b_first");
    t1 = cyc;
    wait_done("b2b_second");
    t2 = cyc;
    req0 = 0;
    chk("b2b_spacing", t2 - t1, 32'd3);
    repeat (2) @(negedge clk);

    // tie from reset
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    op0 = 3'b010; a0 = 16'h0001; b0 = 16'h0002;
    op1 = 3'b010; a1 = 16'h000A; b1 = 16'h0014;
`ifdef ALU_ARB_RR_EN
    for (int i = 0; i < 4; i++)
      q.push_back(i[0] ? '{1'b1, 16'h001E, 1'b0} : '{1'b0, 16'h0003, 1'b0});
`else
    for (int i = 0; i < 4; i++)
      q.push_back('{1'b0, 16'h0003, 1'b0});
    q.push_back('{1'b1, 16'h001E, 1'b0});
`endif
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) wait_done("tie");
    req0 = 0;
`ifndef ALU_ARB_RR_EN
    wait_done("tie_req1");
`endif
    req1 = 0;
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
